// File: rtl/ssd_scan_display.sv
// ssd_scan_display: multiplexed seven-segment scanner with hex/decimal conversion, paging and zero blanking
// A new value reaches the display register only after its conversion finishes, so the scan never shows a partial result.
module ssd_scan_display #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 32,
  parameter int BCD_DIGITS = 10,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] number,
  input  logic              mode,
  input  logic [1:0]        page,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] Anodes,
  output logic [6:0]        Cathodes,
  output logic              busy
);
  localparam int ND = DATA_W / 4 > BCD_DIGITS ? DATA_W / 4 : BCD_DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = 4 * BCD_DIGITS;
  localparam logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t            state;
  logic [DATA_W-1:0] snap_num, bin;
  logic              snap_mode, disp_mode;
  logic [BW-1:0]     bcd, bcd_adj;
  logic [CW-1:0]     cnt;
  logic [4*ND-1:0]   disp;
  logic [SW-1:0]     scan;
  logic [IW-1:0]     idx;
  logic [3:0]        nib;
  logic              blank;
  int                lg, msd, ndig;

  assign busy = state != IDLE;

  always_comb
    for (int i = 0; i < BCD_DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];

  // msd is the highest non-zero digit; an all-zero value leaves it at 0 so digit 0 stays lit
  always_comb begin
    ndig = disp_mode ? BCD_DIGITS : DATA_W / 4;
    lg = int'(page) * DIGITS + int'(idx);
    msd = 0;
    nib = 4'd0;
    for (int i = 0; i < ND; i++) begin
      if (i < ndig && disp[4*i +: 4] != 4'd0) msd = i;
      if (i == lg) nib = disp[4*i +: 4];
    end
    blank = lg >= ndig || (blank_lz && lg > msd);
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      snap_num <= '0;
      snap_mode <= 1'b0;
      disp_mode <= 1'b0;
      disp <= '0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if ({mode, number} != {snap_mode, snap_num}) begin
            snap_mode <= mode;
            snap_num <= number;
            bcd <= '0;
            bin <= number;
            cnt <= CW'(DATA_W);
            state <= mode ? SHIFT : LATCH;
          end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= LATCH;
        end
        default: begin
          disp <= snap_mode ? (4*ND)'(bcd) : (4*ND)'(snap_num);
          disp_mode <= snap_mode;
          state <= IDLE;
        end
      endcase
    end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      scan <= '0;
      idx <= '0;
      Anodes <= '1;
      Cathodes <= '1;
    end else begin
      scan <= scan == SW'(REFRESH_DIV - 1) ? '0 : scan + SW'(1);
      if (scan == SW'(REFRESH_DIV - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      Anodes <= ~(DIGITS'(1) << idx);
      Cathodes <= blank ? 7'h7f : SEG[nib];
    end
endmodule

// File: tb/tb_ssd_scan_display.sv
// tb_ssd_scan_display: per-cycle comparison against an arithmetic display model plus directed literal checks
module tb_ssd_scan_display;
  localparam int R = 4;
  logic        clock = 1'b0, reset_n = 1'b1, mode = 1'b0, blank_lz = 1'b0;
  logic [31:0] number = '0;
  logic [1:0]  page = '0;
  logic [3:0]  Anodes;
  logic [6:0]  Cathodes;
  logic        busy;
  int          checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [31:0] snap = '0, shown = '0;
  logic        smode = 1'b0, shown_mode = 1'b0;
  int          rem = 0, tick = 0;
  logic [3:0]  e_an = '1;
  logic [6:0]  e_cat = 7'h7f;
  logic        e_busy = 1'b0;

  ssd_scan_display #(.DIGITS(4), .DATA_W(32), .BCD_DIGITS(10), .REFRESH_DIV(R)) dut (
    .clock(clock), .reset_n(reset_n), .number(number), .mode(mode), .page(page),
    .blank_lz(blank_lz), .Anodes(Anodes), .Cathodes(Cathodes), .busy(busy));

  always #5 clock = ~clock;

  function automatic logic [6:0] exp_seg(input logic [31:0] v, input logic m, input int l, input logic lz);
    longint unsigned base, p, q;
    int cnt;
    base = m ? 10 : 16;
    cnt = m ? 10 : 8;
    p = 1;
    for (int i = 0; i < l; i++) p = p * base;
    q = {32'd0, v};
    q = q / p;
    if (l >= cnt || (lz && l > 0 && q == 0)) return 7'h7f;
    return seg_tab[int'(q % base)];
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: busy lasts 1 cycle (hex) or 33 cycles (decimal) after a capture; display shows last completed value
  initial forever begin : model
    int sd;
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      snap = '0; smode = 1'b0; shown = '0; shown_mode = 1'b0; rem = 0; tick = 0;
      e_an = '1; e_cat = 7'h7f; e_busy = 1'b0;
    end else begin
      sd = (tick / R) % 4;
      e_an = ~(4'b1 << sd);
      e_cat = exp_seg(shown, shown_mode, int'(page) * 4 + sd, blank_lz);
      tick++;
      if (rem == 0) begin
        if ({mode, number} != {smode, snap}) begin
          smode = mode;
          snap = number;
          rem = mode ? 33 : 1;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          shown = snap;
          shown_mode = smode;
        end
      end
      e_busy = rem != 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("cyc_anodes", {28'd0, Anodes}, {28'd0, e_an});
      check("cyc_cathodes", {25'd0, Cathodes}, {25'd0, e_cat});
      check("cyc_busy", {31'd0, busy}, {31'd0, e_busy});
    end
  end

  task automatic show(input string nm, input int d, input logic [6:0] exp);
    int n;
    n = 0;
    while (Anodes == ~(4'b1 << d) && n < 40) begin @(negedge clock); n++; end
    while (Anodes != ~(4'b1 << d) && n < 40) begin @(negedge clock); n++; end
    if (n >= 40) check({nm, "_timeout"}, n, 0);
    else check(nm, {25'd0, Cathodes}, {25'd0, exp});
  endtask

  task automatic wait_busy(input string nm, input logic lvl, input int lim);
    int n;
    n = 0;
    while (busy !== lvl && n < lim) begin @(negedge clock); n++; end
    if (n >= lim) check({nm, "_timeout"}, n, 0);
  endtask

  initial begin
    int n;
    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      number = 32'hdead0000 + i;
      mode = i[0];
      page = 2'(i);
    end
    check("rst_anodes", {28'd0, Anodes}, 32'hf);
    check("rst_cathodes", {25'd0, Cathodes}, 32'h7f);
    check("rst_busy", {31'd0, busy}, 0);
    number = 32'h1234abcd; mode = 1'b0; page = 2'd0; blank_lz = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("first_anodes", {28'd0, Anodes}, 32'he);
    n = 1;
    while (Anodes == 4'b1110 && n < 20) begin @(negedge clock); if (Anodes == 4'b1110) n++; end
    check("lit_cycles", n, R);
    repeat (4) @(negedge clock);
    show("hex_p0_d0", 0, 7'b0100001);
    show("hex_p0_d1", 1, 7'b1000110);
    show("hex_p0_d2", 2, 7'b0000011);
    show("hex_p0_d3", 3, 7'b0001000);
    page = 2'd1;
    show("hex_p1_d0", 0, 7'b0011001);
    show("hex_p1_d1", 1, 7'b0110000);
    show("hex_p1_d2", 2, 7'b0100100);
    show("hex_p1_d3", 3, 7'b1111001);
    page = 2'd2;
    for (int d = 0; d < 4; d++) show("hex_p2_blank", d, 7'h7f);
    page = 2'd0;
    number = 32'd1234567890; mode = 1'b1;
    wait_busy("dec_rise", 1'b1, 10);
    n = 0;
    while (busy && n < 60) begin @(negedge clock); n++; end
    check("dec_busy_len", n, 33);
    show("dec_d0", 0, 7'b1000000);
    show("dec_d1", 1, 7'b0010000);
    show("dec_d2", 2, 7'b0000000);
    show("dec_d3", 3, 7'b1111000);
    page = 2'd2;
    show("dec_d8", 0, 7'b0100100);
    show("dec_d9", 1, 7'b1111001);
    show("dec_d10", 2, 7'h7f);
    show("dec_d11", 3, 7'h7f);
    page = 2'd0; blank_lz = 1'b1; number = 32'd5;
    wait_busy("lz5_rise", 1'b1, 10);
    wait_busy("lz5_fall", 1'b0, 50);
    show("lz5_d0", 0, 7'b0010010);
    for (int d = 1; d < 4; d++) show("lz5_blank", d, 7'h7f);
    blank_lz = 1'b0;
    for (int d = 1; d < 4; d++) show("nolz5_zero", d, 7'b1000000);
    blank_lz = 1'b1; number = 32'd0;
    wait_busy("lz0_rise", 1'b1, 10);
    wait_busy("lz0_fall", 1'b0, 50);
    show("lz0_d0", 0, 7'b1000000);
    show("lz0_d1", 1, 7'h7f);
    number = 32'd100;
    wait_busy("mid_rise", 1'b1, 10);
    repeat (10) @(negedge clock);
    number = 32'd42;
    wait_busy("mid_fall1", 1'b0, 50);
    @(negedge clock);
    check("mid_rebusy", {31'd0, busy}, 1);
    show("mid_100_d2", 2, 7'b1111001);
    wait_busy("mid_fall2", 1'b0, 60);
    show("mid_42_d0", 0, 7'b0100100);
    show("mid_42_d1", 1, 7'b0011001);
    show("mid_42_d2", 2, 7'h7f);
    number = 32'd777;
    wait_busy("rs_rise", 1'b1, 10);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rs_busy", {31'd0, busy}, 0);
    check("rs_anodes", {28'd0, Anodes}, 32'hf);
    check("rs_cathodes", {25'd0, Cathodes}, 32'h7f);
    @(negedge clock);
    reset_n = 1'b1;
    wait_busy("rs_rise2", 1'b1, 10);
    wait_busy("rs_fall2", 1'b0, 50);
    for (int d = 0; d < 3; d++) show("rs_777", d, 7'b1111000);
    show("rs_d3", 3, 7'h7f);
    repeat (2) @(negedge clock);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssd_scan_display.md
# ssd_scan_display

Parametrised multi-digit seven-segment scanner that succeeds the fixed 4-digit hex display driver used by the single-cycle CPU top level. It adds a hex/decimal mode, a sequential binary-to-BCD converter, page selection for values wider than the physical display, and leading-zero blanking. It sits between the register-file debug read port and the board's anode/cathode pins. Display updates are atomic: a new value appears only after its conversion completes.

## Interface
Parameters:
- DIGITS, 4, number of physical digits scanned.
- DATA_W, 32, width of the value to display; multiple of 4.
- BCD_DIGITS, 10, decimal digits produced by the converter; must cover 2^DATA_W−1.
- REFRESH_DIV, 100000, clock cycles each digit stays lit; ≥2.

Ports:
- clock  in  1  system clock; everything is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- number  in  DATA_W  value to display.
- mode  in  1  0 = hex, 1 = unsigned decimal.
- page  in  2  selects the displayed digit group, digits page*DIGITS … page*DIGITS+DIGITS−1.
- blank_lz  in  1  1 = blank leading zeros.
- Anodes  out  DIGITS  digit enables, active-low.
- Cathodes  out  7  segments {g,f,e,d,c,b,a}, active-low; Cathodes[0] = a.
- busy  out  1  conversion in progress.

## Operation
- Converter FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - Every cycle, compare {mode, number} against the snapshot of the last converted value. On a mismatch, capture a new snapshot.
  - Hex mode: go to LATCH.
  - Decimal mode: clear the BCD accumulator, load the shift register, set the shift count to DATA_W, then go to SHIFT.
- SHIFT: double-dabble, one bit per cycle. First, add 3 to each BCD nibble that is ≥5. Then shift {bcd, bin} left by 1. After DATA_W iterations, go to LATCH.
- LATCH:
  - Copy the result into the display register (digit nibbles, digit count = DATA_W/4 or BCD_DIGITS).
  - Go to IDLE.
- busy = 1 in SHIFT and LATCH.
- Input changes during SHIFT or LATCH are ignored. On return to IDLE the compare sees the new value and restarts conversion. The display register never holds a partial result.
- Scan counter counts 0 … REFRESH_DIV−1. On wrap, the digit index advances by 1 modulo DIGITS.
- The lit digit is Anodes[idx] = 0; all other anode bits are 1.
- Logical digit = page*DIGITS + idx.
  - If it is ≥ the digit count, the digit is blanked.
  - Blanked means Cathodes = 7'b1111111 with the anode still driven.
- Leading-zero blanking (blank_lz = 1): a logical digit above the most significant non-zero digit is blanked. Logical digit 0 is never blanked.
- page and blank_lz act combinationally on the next registered output update. They do not trigger conversion.
- Segment map (active-low): 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.

## Timing
- Reset, asynchronous: Anodes all 1, Cathodes = 7'b1111111, busy = 0, FSM = IDLE, scan counter = 0, idx = 0, snapshot and display register = 0 with mode 0.
- Anodes and Cathodes are registered.
- The first lit digit (idx 0) appears on the first rising edge after reset_n deasserts.
- Latency from a number change to the new digits in the display register:
  - Hex: 3 cycles (compare/capture, LATCH, register).
  - Decimal: DATA_W + 3 cycles.
- busy rises the cycle after the snapshot is captured. It falls the cycle after LATCH.
- Each digit is lit for exactly REFRESH_DIV cycles. idx wraps from DIGITS−1 to 0.
- A mode change alone triggers reconversion of the current number.
- Asserting reset_n mid-SHIFT aborts conversion immediately with no display update.

## Test plan
- Reset: hold reset_n = 0 with activity on the inputs → Anodes = 4'b1111, Cathodes = 7'h7F, busy = 0. After release, the next edge gives Anodes = 4'b1110.
- Hex paging, REFRESH_DIV = 4: number = 32'h1234ABCD, mode 0, page 0 → digits 0..3 show D, C, b, A, each for 4 cycles. Page 1 → 4, 3, 2, 1. Page 2 → all blank.
- Decimal: number = 1234567890, mode 1 → busy high for 33 cycles. Page 0 → digits 0..3 show 0, 9, 8, 7. Page 2 → digit 8 = 2, digit 9 = 1, digits 10–11 blank.
- Leading zeros: decimal 5 with blank_lz = 1 → digit 0 = 0010010 and digits 1–3 = 1111111. With blank_lz = 0 → digits 1–3 = 1000000. Value 0 still shows 0 on digit 0.
- Mid-conversion change: in decimal, change 100 to 42 at SHIFT cycle 10 → 100 is displayed first, busy re-asserts, then 42 is displayed. No other value appears.
- Reset mid-SHIFT: pulse reset_n low during conversion → busy = 0 immediately and the display returns to the reset state. The next conversion of the held input completes normally.
